// File: rtl/pixel_pio_receiver_if.sv
// Bundles the HPS pixel PIO handshake and the frame-buffer write port.
// The receiver uses the slave view and the HPS/frame-buffer side uses the master view.
interface pixel_pio_receiver_if #(
    parameter int ADDR_W  = 19,
    parameter int OUT_BPC = 8
);
    logic [23:0]          pio_data;
    logic [3:0]           pio_status_w;
    logic [15:0]          pio_row;
    logic [3:0]           pio_status_r;
    logic [ADDR_W-1:0]    fb_addr;
    logic [3*OUT_BPC-1:0] fb_wdata;
    logic                 fb_we;
    logic                 fb_ready;
    logic                 frame_valid;

    modport master (
        output pio_data, pio_status_w, fb_ready,
        input  pio_row, pio_status_r, fb_addr, fb_wdata, fb_we, frame_valid
    );

    modport slave (
        input  pio_data, pio_status_w, fb_ready,
        output pio_row, pio_status_r, fb_addr, fb_wdata, fb_we, frame_valid
    );
endinterface

// File: rtl/pixel_pio_receiver.sv
// Receives toggle-handshaked RGB pixels from the HPS PIOs and writes them
// row-major into the frame buffer, reporting row and handshake status back.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no frame active; toggles ignored until SOF
// S_RECV  | waiting for the data toggle to differ from the last one seen
// S_WRITE | fb_we high, holding addr/data until fb_ready
// S_DONE  | last pixel of the frame written; toggles ignored until SOF
module pixel_pio_receiver #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int OUT_BPC = 8
) (
    input logic                 i_clk_clk,
    input logic                 i_reset_reset,
    pixel_pio_receiver_if.slave io_bus
);
    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int DW = 3 * OUT_BPC;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_rst_sync;
    logic              w_rst;
    logic [DW-1:0]     r_d_q;
    logic [2:0]        r_s_q;
    logic              r_sof_prev;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [DW-1:0]     r_wdata;
    logic              r_tog_seen;
    logic              r_ack;
    logic              r_frame_done;
    logic              r_overrun;
    logic              r_frame_valid;
    logic              w_abort;
    logic              w_sof;
    logic              w_tog_diff;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_busy;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge i_clk_clk or posedge i_reset_reset) begin
        if (i_reset_reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst      = r_rst_sync[1];
    assign w_abort    = r_s_q[2];
    assign w_sof      = r_s_q[1] & ~r_sof_prev;
    assign w_tog_diff = r_s_q[0] != r_tog_seen;
    assign w_x_last   = r_x == XW'(H_RES - 1);
    assign w_y_last   = r_y == YW'(V_RES - 1);
    assign w_busy     = r_state == S_WRITE;

    always_ff @(posedge i_clk_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_sof) begin
            w_state_nxt = S_RECV;
        end else begin
            case (r_state)
                S_RECV:  if (w_tog_diff) w_state_nxt = S_WRITE;
                S_WRITE: if (io_bus.fb_ready) w_state_nxt = (w_x_last && w_y_last) ? S_DONE : S_RECV;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk_clk or posedge w_rst) begin
        if (w_rst) begin
            r_d_q         <= '0;
            r_s_q         <= '0;
            r_sof_prev    <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_tog_seen    <= 1'b0;
            r_ack         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            // Only the kept MSBs of each channel are ever needed downstream.
            r_d_q         <= {io_bus.pio_data[23 -: OUT_BPC],
                              io_bus.pio_data[15 -: OUT_BPC],
                              io_bus.pio_data[7 -: OUT_BPC]};
            r_s_q         <= io_bus.pio_status_w[2:0];
            r_sof_prev    <= r_s_q[1];
            r_frame_valid <= 1'b0;
            if (w_abort) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= '0;
            end else if (w_sof) begin
                r_x          <= '0;
                r_y          <= '0;
                r_addr       <= '0;
                r_tog_seen   <= r_s_q[0];
                r_ack        <= r_s_q[0];
                r_frame_done <= 1'b0;
                r_overrun    <= 1'b0;
            end else begin
                case (r_state)
                    S_RECV: begin
                        if (w_tog_diff) begin
                            r_wdata    <= r_d_q;
                            r_tog_seen <= r_s_q[0];
                        end
                    end
                    S_WRITE: begin
                        if (w_tog_diff) r_overrun <= 1'b1;
                        if (io_bus.fb_ready) begin
                            r_ack <= r_tog_seen;
                            if (w_x_last) begin
                                r_x <= '0;
                                if (w_y_last) begin
                                    r_y           <= '0;
                                    r_addr        <= '0;
                                    r_frame_done  <= 1'b1;
                                    r_frame_valid <= 1'b1;
                                end else begin
                                    r_y    <= r_y + YW'(1);
                                    r_addr <= r_addr + ADDR_W'(1);
                                end
                            end else begin
                                r_x    <= r_x + XW'(1);
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_bus.pio_row      = 16'(r_y);
    assign io_bus.pio_status_r = {r_overrun, r_frame_done, w_busy, r_ack};
    assign io_bus.fb_addr      = r_addr;
    assign io_bus.fb_wdata     = r_wdata;
    assign io_bus.fb_we        = w_busy;
    assign io_bus.frame_valid  = r_frame_valid;
endmodule

// File: tb/tb_pixel_pio_receiver.sv
// Scoreboard bench for pixel_pio_receiver on a small 4x2 frame with 4-bit channels.
module tb_pixel_pio_receiver;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int AW  = 5;
    localparam int BPC = 4;
    localparam int DW  = 3 * BPC;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_pio_receiver_if #(.ADDR_W(AW), .OUT_BPC(BPC)) bus ();

    pixel_pio_receiver #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .OUT_BPC(BPC)) dut (
        .i_clk_clk    (clk),
        .i_reset_reset(rst),
        .io_bus       (bus)
    );

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          tog   = 1'b0;
    bit            rdy_rand = 1'b0;
    bit            exp_fv = 1'b0;
    int            mx = 0, my = 0;
    bit            m_active = 1'b0, m_done = 1'b0, m_ovr = 1'b0;
    logic          m_ack = 1'b0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_pix(input logic [23:0] p);
        int r, g, b;
        r = ((p >> 16) & 255) >> (8 - BPC);
        g = ((p >> 8) & 255) >> (8 - BPC);
        b = (p & 255) >> (8 - BPC);
        return DW'((r << (2 * BPC)) + (g << BPC) + b);
    endfunction

    // Monitor: every accepted write must match the oldest expected pixel.
    always @(negedge clk) begin
        exp_t e;
        chk("frame_valid", 32'(bus.frame_valid), 32'(exp_fv));
        exp_fv = 1'b0;
        if (bus.fb_we === 1'b1 && bus.fb_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 32'(bus.fb_addr), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("fb_addr", 32'(bus.fb_addr), 32'(e.addr));
                chk("fb_wdata", 32'(bus.fb_wdata), 32'(e.data));
                exp_fv = e.last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) bus.fb_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_sof();
        bus.pio_status_w[1] = 1'b1;
        ticks(2);
        bus.pio_status_w[1] = 1'b0;
        ticks(2);
        mx = 0; my = 0; m_active = 1'b1; m_done = 1'b0; m_ovr = 1'b0; m_ack = tog;
        chk("sof_ack", 32'(bus.pio_status_r[0]), 32'(m_ack));
        chk("sof_status", 32'(bus.pio_status_r[3:1]), 32'(0));
        chk("sof_row", 32'(bus.pio_row), 32'(0));
    endtask

    // Issue one toggle; returns whether the model expects it to be written.
    task automatic issue(input logic [23:0] pix, output bit taken);
        exp_t e;
        bus.pio_data = pix;
        tog = ~tog;
        bus.pio_status_w[0] = tog;
        taken = m_active;
        if (m_active) begin
            e.addr = AW'(my * H + mx);
            e.data = model_pix(pix);
            e.last = (mx == H - 1) && (my == V - 1);
            last_addr = e.addr;
            last_data = e.data;
            q.push_back(e);
            if (mx == H - 1) begin
                mx = 0;
                if (my == V - 1) begin
                    my = 0; m_active = 1'b0; m_done = 1'b1;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    task automatic wait_ack();
        int k = 0;
        while (bus.pio_status_r[0] !== tog && k < 200) begin tick(); k++; end
        chk("ack", 32'(bus.pio_status_r[0]), 32'(tog));
        m_ack = tog;
        chk("row", 32'(bus.pio_row), 32'(my));
        chk("busy_idle", 32'(bus.pio_status_r[1]), 32'(0));
        chk("frame_done", 32'(bus.pio_status_r[2]), 32'(m_done));
        chk("overrun", 32'(bus.pio_status_r[3]), 32'(m_ovr));
    endtask

    task automatic send_px(input logic [23:0] pix);
        bit taken;
        issue(pix, taken);
        if (taken) begin
            wait_ack();
        end else begin
            ticks(8);
            chk("ignored_ack", 32'(bus.pio_status_r[0]), 32'(m_ack));
            chk("ignored_we", 32'(bus.fb_we), 32'(0));
        end
    endtask

    task automatic send_lat(input logic [23:0] pix);
        bit taken;
        issue(pix, taken);
        tick();
        chk("lat_we_n1", 32'(bus.fb_we), 32'(0));
        tick();
        chk("lat_we_n2", 32'(bus.fb_we), 32'(1));
        chk("lat_busy_n2", 32'(bus.pio_status_r[1]), 32'(1));
        tick();
        chk("lat_ack_n3", 32'(bus.pio_status_r[0]), 32'(tog));
        chk("lat_we_n3", 32'(bus.fb_we), 32'(0));
        wait_ack();
    endtask

    task automatic wait_we();
        int k = 0;
        while (bus.fb_we !== 1'b1 && k < 50) begin tick(); k++; end
        chk("we_rise", 32'(bus.fb_we), 32'(1));
    endtask

    task automatic do_abort(input bit pending);
        bus.pio_status_w[2] = 1'b1;
        tick();
        if (pending) chk("abort_we_hold", 32'(bus.fb_we), 32'(1));
        tick();
        chk("abort_we", 32'(bus.fb_we), 32'(0));
        chk("abort_row", 32'(bus.pio_row), 32'(0));
        chk("abort_addr", 32'(bus.fb_addr), 32'(0));
        chk("abort_status", 32'(bus.pio_status_r[3:1]), 32'({m_ovr, m_done, 1'b0}));
        if (pending) void'(q.pop_back());
        bus.pio_status_w[2] = 1'b0;
        ticks(2);
        mx = 0; my = 0; m_active = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_we"}, 32'(bus.fb_we), 32'(0));
        chk({nm, "_addr"}, 32'(bus.fb_addr), 32'(0));
        chk({nm, "_wdata"}, 32'(bus.fb_wdata), 32'(0));
        chk({nm, "_row"}, 32'(bus.pio_row), 32'(0));
        chk({nm, "_status"}, 32'(bus.pio_status_r), 32'(0));
        chk({nm, "_fv"}, 32'(bus.frame_valid), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.pio_data = '0;
        bus.pio_status_w = '0;
        bus.fb_ready = 1'b0;
        ticks(3);
        check_all_zero("reset");
        rst = 1'b0;
        ticks(4);

        // Basic frame: latency, three fixed pixels, then to frame end.
        bus.fb_ready = 1'b1;
        do_sof();
        send_lat(24'hFF8040);
        send_lat(24'h00FF00);
        send_lat(24'h0000FF);
        for (int i = 3; i < H * V; i++) send_px(24'($urandom));
        send_px(24'h123456);

        // Stalled write holds address/data and ack.
        do_sof();
        bus.fb_ready = 1'b0;
        begin
            bit taken;
            issue(24'h5A5A5A, taken);
        end
        wait_we();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_we", 32'(bus.fb_we), 32'(1));
            chk("stall_addr", 32'(bus.fb_addr), 32'(last_addr));
            chk("stall_data", 32'(bus.fb_wdata), 32'(last_data));
            chk("stall_ack", 32'(bus.pio_status_r[0]), 32'(m_ack));
        end
        bus.fb_ready = 1'b1;
        tick();
        chk("stall_release_ack", 32'(bus.pio_status_r[0]), 32'(tog));
        wait_ack();

        // Double toggle during a stall flags overrun with no extra pixel.
        bus.fb_ready = 1'b0;
        begin
            bit taken;
            issue(24'hC0FFEE, taken);
        end
        wait_we();
        tog = ~tog; bus.pio_status_w[0] = tog; ticks(3);
        tog = ~tog; bus.pio_status_w[0] = tog; ticks(3);
        m_ovr = 1'b1;
        chk("overrun_set", 32'(bus.pio_status_r[3]), 32'(1));
        bus.fb_ready = 1'b1;
        wait_ack();
        ticks(10);
        chk("overrun_no_extra", 32'(bus.fb_we), 32'(0));
        do_sof();

        // Abort with a write pending, then ignored toggle, then fresh frame.
        send_px(24'h111111);
        send_px(24'h222222);
        bus.fb_ready = 1'b0;
        begin
            bit taken;
            issue(24'h333333, taken);
        end
        wait_we();
        do_abort(1'b1);
        bus.fb_ready = 1'b1;
        send_px(24'h444444);
        do_sof();
        send_px(24'hABCDEF);
        chk("trunc_abcdef", 32'(bus.fb_wdata), 32'h0000_0ACE);

        // Asynchronous reset in the middle of a stalled write.
        bus.fb_ready = 1'b0;
        begin
            bit taken;
            issue(24'h777777, taken);
        end
        wait_we();
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        q.delete();
        m_ack = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_active = 1'b0;
        ticks(2);
        rst = 1'b0;
        ticks(4);

        // Randomized frames with random back-pressure and occasional aborts.
        rdy_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            do_sof();
            n = $urandom_range(1, H * V + 2);
            for (int i = 0; i < n; i++) begin
                if (m_active && $urandom_range(0, 15) == 0) do_abort(1'b0);
                send_px(24'($urandom));
            end
        end
        rdy_rand = 1'b0;
        bus.fb_ready = 1'b1;
        ticks(4);
        chk("queue_drained", 32'(q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
